led_blink_sequencer: RTL and testbench
======================================

# led_blink_sequencer

- Command-driven controller for the board's two status LEDs.
- Owns the blink prescaler and sequences the LEDs through static, in-phase blink and alternating blink patterns.
- Blinks run for a programmed number of periods, or continuously.
- Sits between the control logic issuing status commands and the LED pins, replacing free-running blink counters.

## Interface
- HALF_PERIOD, 25_000_000, clock cycles per blink phase (0.5 s at 50 MHz); must be ≥ 2.
- CNT_W, 25, prescaler width; must hold HALF_PERIOD-1.
- sys_clk_50M  input  1  system clock, 50 MHz; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command can be accepted this cycle.
- cmd_mode  input  2  pattern select:
  - 00 = off
  - 01 = on
  - 10 = in-phase blink
  - 11 = alternating blink
- cmd_count  input  8  number of full blink periods; 0 = continuous. Ignored for modes 00/01.
- abort  input  1  stop current blink. Present only with LED_SEQ_ABORT_EN.
- led  output  2  LED drive, 1 = lit.
- busy  output  1  blink sequence in progress.
- done  output  1  one-cycle pulse when a counted sequence completes.

## Operation
- States:
  - IDLE: led holds its last static value.
  - PH_A: first half of each blink period.
  - PH_B: second half of each blink period.
- cmd_ready = 1 in IDLE, and in PH_A/PH_B when the running command is continuous (remaining count = 0).
  - With LED_SEQ_ABORT_EN, cmd_ready is forced to 0 while abort = 1.
- Accept = cmd_valid && cmd_ready at a rising edge. Command fields are sampled only at accept.
- Mode 00 or 01 accepted:
  - Next state IDLE; led <= 00 or 11 respectively.
  - No done pulse, busy stays 0.
- Mode 10 or 11 accepted:
  - Next state PH_A; prescaler <= 0; remaining <= cmd_count.
  - Mode is latched.
- Blink patterns:
  - Mode 10: PH_A led = 11, PH_B led = 00.
  - Mode 11: PH_A led = 01, PH_B led = 10.
- Prescaler counts 0..HALF_PERIOD-1 while in PH_A/PH_B. At HALF_PERIOD-1 it wraps to 0 and the phase ends.
- End of PH_A: go to PH_B.
- End of PH_B:
  - remaining = 0 (continuous): go to PH_A.
  - remaining = 1: go to IDLE; led <= 00; done <= 1 for one cycle.
  - Otherwise: remaining decrements by 1; go to PH_A.
- New command accepted during continuous run: restart at PH_A with the new parameters, prescaler cleared, no done pulse.
  - A static command (00/01) ends the run immediately with the new static led value.
- busy = 1 exactly when the state is PH_A or PH_B.

## Timing
- Reset values:
  - state IDLE, led = 00, busy = 0, done = 0, cmd_ready = 1.
  - prescaler = 0, remaining = 0.
- Accept at edge T: led, busy and state update at T (visible cycle T+1). No combinational path from cmd_* to led.
- Phase length is exactly HALF_PERIOD cycles; a period is 2·HALF_PERIOD cycles.
- Counted blink, count N: busy high for exactly 2·N·HALF_PERIOD cycles.
  - done is asserted on the first cycle busy is low, coincident with led = 00.
- done and cmd_ready are both high in that cycle.
  - A command accepted then takes effect normally; done still pulses for exactly one cycle.
- rst mid-sequence: all outputs return to reset values immediately; no done pulse.
- cmd_count = 0 with mode 10/11 never produces done.

## Configuration
- LED_SEQ_ABORT_EN defined:
  - The abort port exists.
  - abort = 1 in PH_A/PH_B forces IDLE, led <= 00 and prescaler <= 0 at the next edge, with no done pulse.
  - abort has priority over phase end and over a simultaneous command, which is not accepted.
  - abort in IDLE has no effect.
- Not defined:
  - No abort port.
  - A counted sequence always runs to completion; only rst or a new command during continuous mode stops it.

## Test plan
All scenarios use HALF_PERIOD = 4.
- Reset, then mode 01 → led = 11 the cycle after accept; busy = 0; done never pulses. Then mode 00 → led = 00.
- Mode 10, count 2 → led sequence 11×4, 00×4, 11×4, 00×4; busy high 16 cycles; done one cycle with led = 00.
- Mode 11, count 0 → led alternates 01/10 every 4 cycles for ≥ 40 cycles; cmd_ready = 1 throughout. Mode 10, count 1 at cycle 10 → restart with 11 the next cycle; done after 8 cycles.
- Mode 10, count 3; cmd_valid held high mid-run → cmd_ready = 0 until done; a new command is accepted in the done cycle.
- rst asserted at cycle 6 of a count-3 blink → led = 00, busy = 0 immediately; no done pulse.
- With LED_SEQ_ABORT_EN: abort at cycle 5 of mode 10, count 5 → IDLE and led = 00 the next cycle; no done. Abort together with a command in continuous mode → command not accepted.

Source files
------------

// File: rtl/led_blink_sequencer.sv
// rtl/led_blink_sequencer.sv - command-driven static/blink sequencer for two status LEDs
// Optional abort input is compiled in when LED_SEQ_ABORT_EN is defined.
module led_blink_sequencer #(
    parameter int HALF_PERIOD = 25_000_000,
    parameter int CNT_W       = 25
) (
    input  logic             sys_clk_50M,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [7:0]       cmd_count,
`ifdef LED_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       led,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rem_q, rem_d;
    logic             alt_q, alt_d;
    logic [1:0]       led_q, led_d;
    logic             done_q, done_d;

    logic abort_hit;
    logic running;
    logic phase_end;
    logic accept;

`ifdef LED_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign running   = (state_q == PH_A) || (state_q == PH_B);
    assign phase_end = running && (cnt_q == CNT_W'(HALF_PERIOD - 1));
    // A counted run cannot be pre-empted; only continuous runs (rem = 0) take new commands.
    assign cmd_ready = ((state_q == IDLE) || (rem_q == 8'd0)) && !abort_hit;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        alt_d   = alt_q;
        led_d   = led_q;
        done_d  = 1'b0;

        if (abort_hit && running) begin
            state_d = IDLE;
            led_d   = 2'b00;
            cnt_d   = '0;
        end else if (accept) begin
            cnt_d = '0;
            if (!cmd_mode[1]) begin
                state_d = IDLE;
                led_d   = {2{cmd_mode[0]}};
            end else begin
                state_d = PH_A;
                rem_d   = cmd_count;
                alt_d   = cmd_mode[0];
                led_d   = cmd_mode[0] ? 2'b01 : 2'b11;
            end
        end else if (running) begin
            if (!phase_end) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
                if (state_q == PH_A) begin
                    state_d = PH_B;
                    led_d   = alt_q ? 2'b10 : 2'b00;
                end else if (rem_q == 8'd1) begin
                    state_d = IDLE;
                    rem_d   = 8'd0;
                    led_d   = 2'b00;
                    done_d  = 1'b1;
                end else begin
                    if (rem_q != 8'd0) begin
                        rem_d = rem_q - 8'd1;
                    end
                    state_d = PH_A;
                    led_d   = alt_q ? 2'b01 : 2'b11;
                end
            end
        end
    end

    always_ff @(posedge sys_clk_50M or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= 8'd0;
            alt_q   <= 1'b0;
            led_q   <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            alt_q   <= alt_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = running;
    assign done = done_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb/tb_led_blink_sequencer.sv - randomized self-checking bench against a time-based LED model
module tb_led_blink_sequencer;

    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_mode = 2'b00;
    logic [7:0] cmd_count = 8'd0;
    logic       abort = 1'b0;
    logic       cmd_ready;
    logic [1:0] led;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    // Reference: a blink is described by elapsed cycles since start, not by phase counters.
    bit         m_blink;
    int         m_t;
    int         m_cnt;
    bit         m_alt;
    logic [1:0] m_led;
    bit         m_done;

    always #5 clk = ~clk;

    led_blink_sequencer #(
        .HALF_PERIOD(HP),
        .CNT_W(3)
    ) dut (
        .sys_clk_50M(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode),
        .cmd_count(cmd_count),
`ifdef LED_SEQ_ABORT_EN
        .abort(abort),
`endif
        .led(led),
        .busy(busy),
        .done(done)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_led();
        if (!m_blink) return m_led;
        if (((m_t / HP) % 2) == 0) return m_alt ? 2'b01 : 2'b11;
        return m_alt ? 2'b10 : 2'b00;
    endfunction

    function automatic bit exp_ready();
        bit r;
        r = !m_blink || (m_cnt == 0);
`ifdef LED_SEQ_ABORT_EN
        if (abort) r = 1'b0;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_blink = 1'b0;
        m_t     = 0;
        m_cnt   = 0;
        m_alt   = 1'b0;
        m_led   = 2'b00;
        m_done  = 1'b0;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".led"},   8'(led),       8'(exp_led()));
        check({where, ".busy"},  8'(busy),      8'(m_blink));
        check({where, ".done"},  8'(done),      8'(m_done));
        check({where, ".ready"}, 8'(cmd_ready), 8'(exp_ready()));
    endtask

    task automatic model_edge();
        bit acc;
        acc = cmd_valid && exp_ready();
        m_done = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
`ifdef LED_SEQ_ABORT_EN
        if (abort && m_blink) begin
            m_blink = 1'b0;
            m_led   = 2'b00;
            return;
        end
`endif
        if (acc) begin
            if (cmd_mode < 2) begin
                m_blink = 1'b0;
                m_led   = (cmd_mode == 2'b01) ? 2'b11 : 2'b00;
            end else begin
                m_blink = 1'b1;
                m_t     = 0;
                m_cnt   = int'(cmd_count);
                m_alt   = cmd_mode[0];
            end
        end else if (m_blink) begin
            m_t++;
            if (m_cnt != 0 && m_t == 2 * m_cnt * HP) begin
                m_blink = 1'b0;
                m_led   = 2'b00;
                m_done  = 1'b1;
            end
        end
    endtask

    task automatic cycle(input string where);
        @(negedge clk);
        check_outputs(where);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string where, input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(where);
    endtask

    task automatic issue(input string where, input logic [1:0] mode, input logic [7:0] cnt);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_count = cnt;
        cycle(where);
        cmd_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs("reset_async");
        cycle("reset");
        cycle("reset");
        rst = 1'b0;

        issue("on", 2'b01, 8'd7);
        idle("on_hold", 5);
        issue("off", 2'b00, 8'd0);
        idle("off_hold", 3);

        issue("blink10_n2", 2'b10, 8'd2);
        idle("blink10_n2", 20);

        issue("alt_cont", 2'b11, 8'd0);
        idle("alt_cont", 9);
        issue("restart_n1", 2'b10, 8'd1);
        idle("restart_n1", 12);
        issue("alt_cont2", 2'b11, 8'd0);
        idle("alt_cont2", 44);
        issue("off2", 2'b00, 8'd0);

        issue("blink_n3", 2'b10, 8'd3);
        idle("blink_n3", 5);
        cmd_valid = 1'b1;
        cmd_mode  = 2'b11;
        cmd_count = 8'd1;
        for (int i = 0; i < 30; i++) cycle("held_valid");
        idle("held_valid_tail", 10);

        issue("rst_mid", 2'b10, 8'd3);
        idle("rst_mid", 5);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_mid_async");
        cycle("rst_mid_hold");
        rst = 1'b0;
        idle("rst_mid_after", 30);

`ifdef LED_SEQ_ABORT_EN
        issue("abort_run", 2'b10, 8'd5);
        idle("abort_run", 4);
        abort = 1'b1;
        cycle("abort_run");
        abort = 1'b0;
        idle("abort_after", 10);
        issue("abort_cont", 2'b11, 8'd0);
        idle("abort_cont", 3);
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_mode  = 2'b01;
        cycle("abort_cmd");
        abort     = 1'b0;
        idle("abort_cmd_after", 4);
        abort = 1'b1;
        idle("abort_idle", 2);
        abort = 1'b0;
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                cmd_valid = $urandom_range(0, 2) == 0;
                cmd_mode  = 2'($urandom_range(0, 3));
                cmd_count = 8'($urandom_range(0, 3));
            end
`ifdef LED_SEQ_ABORT_EN
            abort = $urandom_range(0, 19) == 0;
`endif
            cycle("random");
        end
        rst   = 1'b0;
        abort = 1'b0;
        idle("final", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
